regfile_alu_seq: RTL and testbench

Parametrised register-file datapath. A host-loaded register file feeds a sequenced ALU through a start/busy/done handshake. Single-cycle logic and arithmetic ops sit alongside a multi-cycle shift-add multiplier, with optional write-back of the result into the register file. This is the next-generation operand store and execution unit for the lab datapath: a 4-bit/16-entry instance is the drop-in successor of the current fixed-width design.

---
 rtl/regfile_alu_seq.sv | 135 +++++++++++++
 tb/tb_regfile_alu_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_seq.sv
// rtl/regfile_alu_seq.sv - host-loaded register file feeding a sequenced ALU with shift-add multiply
// Operands are latched at start; the result register, flags and write-back update together on EXEC->DONE.
module regfile_alu_seq #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data,
  input  logic [ADDR_W-1:0]   addrop1,
  input  logic [ADDR_W-1:0]   addrop2,
  input  logic [2:0]          opcode,
  input  logic                start,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                sel,
  output logic [2*DATA_W-1:0] out,
  output logic                busy,
  output logic                done,
  output logic                zero,
  output logic                carry
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_MAXU = 3'd6;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state, next_state;
  logic [DATA_W-1:0]   rf [DEPTH];
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2:0]          op_q;
  logic                wb_en_q;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic [RES_W-1:0]    result_q;
  logic [RES_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;

  logic [RES_W-1:0]    alu_res;
  logic                alu_carry;
  logic                finish;
  logic [RES_W-1:0]    mul_sum;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W-1:0]   sub_diff;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    alu_res    = '0;
    alu_carry  = 1'b0;
    finish     = 1'b0;
    add_sum    = {1'b0, a_q} + {1'b0, b_q};
    sub_diff   = a_q - b_q;
    // One partial product per EXEC cycle; the last one lands straight in the result register.
    mul_sum    = acc + (b_q[cnt] ? (RES_W'(a_q) << cnt) : '0);
    case (state)
      IDLE: if (start) next_state = EXEC;
      EXEC: begin
        finish = 1'b1;
        case (op_q)
          OP_ADD:  begin alu_res = RES_W'(add_sum); alu_carry = add_sum[DATA_W]; end
          OP_SUB:  begin alu_res = RES_W'(sub_diff); alu_carry = (a_q < b_q); end
          OP_AND:  alu_res = RES_W'(a_q & b_q);
          OP_OR:   alu_res = RES_W'(a_q | b_q);
          OP_XOR:  alu_res = RES_W'(a_q ^ b_q);
          OP_MUL:  begin alu_res = mul_sum; finish = (cnt == CNT_W'(DATA_W - 1)); end
          OP_MAXU: alu_res = RES_W'((a_q > b_q) ? a_q : b_q);
          default: alu_res = RES_W'(a_q);
        endcase
        if (finish) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      result_q  <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (state == IDLE) begin
        if (we) rf[addr] <= data;
        if (start) begin
          a_q       <= rf[addrop1];
          b_q       <= rf[addrop2];
          op_q      <= opcode;
          wb_en_q   <= wb_en;
          wb_addr_q <= wb_addr;
          acc       <= '0;
          cnt       <= '0;
        end
      end
      if (state == EXEC) begin
        acc <= mul_sum;
        cnt <= cnt + 1'b1;
        if (finish) begin
          result_q <= alu_res;
          zero     <= (alu_res == '0);
          carry    <= alu_carry;
          if (wb_en_q) rf[wb_addr_q] <= alu_res[DATA_W-1:0];
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign out  = sel ? RES_W'(rf[addr]) : result_q;

endmodule

// File: tb/tb_regfile_alu_seq.sv
// tb/tb_regfile_alu_seq.sv - directed bench for regfile_alu_seq with a done-driven scoreboard
// Stimulus pushes expected op results; the monitor pops one per done pulse.
module tb_regfile_alu_seq;

  logic       clock = 1'b0;
  logic       reset, we, start, wb_en, sel;
  logic [3:0] addr, data, addrop1, addrop2, wb_addr;
  logic [2:0] opcode;
  logic [7:0] out;
  logic       busy, done, zero, carry;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] o;
    logic       z;
    logic       c;
  } exp_t;
  exp_t sb[$];

  regfile_alu_seq #(.DATA_W(4), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .we(we), .addr(addr), .data(data),
    .addrop1(addrop1), .addrop2(addrop2), .opcode(opcode), .start(start),
    .wb_en(wb_en), .wb_addr(wb_addr), .sel(sel), .out(out),
    .busy(busy), .done(done), .zero(zero), .carry(carry)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("op_out", out, e.o);
        chk("op_zero", zero, e.z);
        chk("op_carry", carry, e.c);
      end
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clock);
    we = 1'b1; addr = 4'(a); data = 4'(d);
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic rd(input string name, input int a, input int exp);
    @(negedge clock);
    sel = 1'b1; addr = 4'(a);
    #1;
    chk(name, out, exp);
    sel = 1'b0;
  endtask

  // intrude: hold start and a host write to r0 for the whole busy window.
  // cowrite: host write r0<=3 in the same cycle as start.
  task automatic run_op(input int a1, input int a2, input int op, input int wb, input int wba,
                        input int eo, input int ez, input int ec, input int lat_exp,
                        input bit intrude, input bit cowrite);
    int lat;
    exp_t e;
    @(negedge clock);
    addrop1 = 4'(a1); addrop2 = 4'(a2); opcode = 3'(op);
    wb_en = wb[0]; wb_addr = 4'(wba); sel = 1'b0; start = 1'b1;
    we = cowrite; addr = 4'd0; data = 4'd3;
    e.o = 8'(eo); e.z = ez[0]; e.c = ec[0];
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (intrude) begin
      opcode = 3'd0; we = 1'b1; addr = 4'd0; data = 4'd3;
    end else begin
      start = 1'b0; we = 1'b0;
    end
    chk("busy_after_start", busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("done_latency", lat, lat_exp);
    @(posedge clock);
    #1;
    start = 1'b0; we = 1'b0; wb_en = 1'b0;
    chk("idle_after_done", {busy, done}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; we = 1'b0; start = 1'b0; wb_en = 1'b0; sel = 1'b0;
    addr = '0; data = '0; addrop1 = '0; addrop2 = '0; wb_addr = '0; opcode = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset_out", out, 0);
    chk("reset_flags", {busy, done, zero, carry}, 0);

    wr(0, 10); wr(1, 12); wr(2, 5); wr(3, 6); wr(4, 14); wr(5, 15);
    rd("rd_r0", 0, 10); rd("rd_r1", 1, 12); rd("rd_r2", 2, 5);
    rd("rd_r3", 3, 6);  rd("rd_r4", 4, 14); rd("rd_r5", 5, 15);

    run_op(0, 4, 0, 0, 0, 24, 0, 1, 1, 0, 0);   // ADD 10+14
    run_op(2, 2, 1, 0, 0, 0, 1, 0, 1, 0, 0);    // SUB 5-5
    run_op(2, 3, 1, 0, 0, 15, 0, 1, 1, 0, 0);   // SUB 5-6 borrow
    run_op(0, 1, 2, 0, 0, 8, 0, 0, 1, 0, 0);    // AND
    run_op(0, 1, 3, 0, 0, 14, 0, 0, 1, 0, 0);   // OR
    run_op(0, 1, 4, 0, 0, 6, 0, 0, 1, 0, 0);    // XOR
    run_op(2, 3, 6, 0, 0, 6, 0, 0, 1, 0, 0);    // MAXU
    run_op(5, 0, 7, 0, 0, 15, 0, 0, 1, 0, 0);   // PASS A

    // MUL with start and host write hammering throughout busy
    run_op(4, 1, 5, 0, 0, 168, 0, 0, 4, 1, 0);
    @(negedge clock);
    sel = 1'b0;
    #1;
    chk("mul_result_held", out, 168);
    rd("rd_r0_blocked", 0, 10);

    run_op(2, 3, 0, 1, 6, 11, 0, 0, 1, 0, 0);   // ADD wb r6
    rd("rd_r6_wb", 6, 11);
    run_op(4, 5, 0, 1, 7, 29, 0, 1, 1, 0, 0);   // ADD wb r7 truncated
    rd("rd_r7_wb", 7, 13);

    run_op(0, 1, 0, 0, 0, 22, 0, 1, 1, 0, 1);   // host write concurrent with start
    rd("rd_r0_cowrite", 0, 3);

    // reset mid-MUL with a pending write-back
    @(negedge clock);
    addrop1 = 4'd4; addrop2 = 4'd1; opcode = 3'd5; wb_en = 1'b1; wb_addr = 4'd8;
    sel = 1'b0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0; wb_en = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_mid_busy_done", {busy, done}, 0);
    chk("rst_mid_out", out, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) rd("rst_mid_rf", i, 0);
    repeat (8) @(posedge clock);
    #1;
    chk("rst_mid_no_wb", {busy, done}, 0);
    rd("rst_mid_rf8", 8, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
